// File: rtl/spi_cs_txn_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_cs_txn_ctrl_if
// Brief    : Upstream byte stream, SPI-master handshake and chip-select bundle
//            for spi_cs_txn_ctrl.
// Revision : 1.0
// ============================================================================
interface spi_cs_txn_ctrl_if #(
    parameter int MAX_BYTES = 8
) ();
    localparam int c_CW = $clog2(MAX_BYTES + 1);

    logic            i_Start;
    logic [c_CW-1:0] i_Byte_Count;
    logic            o_Busy;
    logic [7:0]      i_TX_Byte;
    logic            i_TX_Valid;
    logic            o_TX_Ready;
    logic [7:0]      o_RX_Byte;
    logic            o_RX_DV;
    logic            o_RX_Last;
    logic            o_Done;
    logic [7:0]      o_M_TX_Byte;
    logic            o_M_TX_DV;
    logic            i_M_TX_Ready;
    logic            i_M_RX_DV;
    logic [7:0]      i_M_RX_Byte;
    logic            o_SPI_CS_n;

    // master is the controller itself; slave is everything around it
    modport master (
        input  i_Start, i_Byte_Count, i_TX_Byte, i_TX_Valid,
               i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
        output o_Busy, o_TX_Ready, o_RX_Byte, o_RX_DV, o_RX_Last, o_Done,
               o_M_TX_Byte, o_M_TX_DV, o_SPI_CS_n
    );

    modport slave (
        output i_Start, i_Byte_Count, i_TX_Byte, i_TX_Valid,
               i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
        input  o_Busy, o_TX_Ready, o_RX_Byte, o_RX_DV, o_RX_Last, o_Done,
               o_M_TX_Byte, o_M_TX_DV, o_SPI_CS_n
    );
endinterface
`default_nettype wire

// File: rtl/spi_cs_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_cs_txn_ctrl
// Brief    : Chip-select transaction controller in front of a byte SPI master.
// Revision : 1.0
// ============================================================================
module spi_cs_txn_ctrl #(
    parameter int MAX_BYTES        = 8,
    parameter int CS_LEAD_CLKS     = 2,
    parameter int CS_INACTIVE_CLKS = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    spi_cs_txn_ctrl_if.master bus
);
    localparam int c_CW   = $clog2(MAX_BYTES + 1);
    localparam int c_TMAX = (CS_LEAD_CLKS > CS_INACTIVE_CLKS) ? CS_LEAD_CLKS : CS_INACTIVE_CLKS;
    localparam int c_TW   = $clog2(c_TMAX + 1);

    localparam logic [c_TW-1:0] c_LEAD_LAST = c_TW'(CS_LEAD_CLKS - 1);
    localparam logic [c_TW-1:0] c_GAP_LAST  = c_TW'(CS_INACTIVE_CLKS - 1);
    localparam logic [c_CW-1:0] c_MAX_CNT   = c_CW'(MAX_BYTES);
    localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEAD    = 3'd1,
        S_FETCH   = 3'd2,
        S_ISSUE   = 3'd3,
        S_WAIT_RX = 3'd4,
        S_LAG     = 3'd5,
        S_GAP     = 3'd6
    } state_t;

    state_t          r_state,     w_state_nxt;
    logic [c_CW-1:0] r_rem,       w_rem_nxt;
    logic [c_TW-1:0] r_cnt,       w_cnt_nxt;
    logic            r_cs_n,      w_cs_n_nxt;
    logic [7:0]      r_m_tx_byte, w_m_tx_byte_nxt;
    logic            r_m_tx_dv,   w_m_tx_dv_nxt;
    logic [7:0]      r_rx_byte,   w_rx_byte_nxt;
    logic            r_rx_dv,     w_rx_dv_nxt;
    logic            r_rx_last,   w_rx_last_nxt;
    logic            r_done,      w_done_nxt;
    logic            w_start_ok;

    // The o_Done cycle already sits in IDLE, so a start there is masked off.
    assign w_start_ok = bus.i_Start && !r_done &&
                        (bus.i_Byte_Count != '0) && (bus.i_Byte_Count <= c_MAX_CNT);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_cs_n      <= 1'b1;
            r_m_tx_byte <= '0;
            r_m_tx_dv   <= 1'b0;
            r_rx_byte   <= '0;
            r_rx_dv     <= 1'b0;
            r_rx_last   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cs_n      <= w_cs_n_nxt;
            r_m_tx_byte <= w_m_tx_byte_nxt;
            r_m_tx_dv   <= w_m_tx_dv_nxt;
            r_rx_byte   <= w_rx_byte_nxt;
            r_rx_dv     <= w_rx_dv_nxt;
            r_rx_last   <= w_rx_last_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rem_nxt       = r_rem;
        w_cnt_nxt       = r_cnt;
        w_cs_n_nxt      = r_cs_n;
        w_m_tx_byte_nxt = r_m_tx_byte;
        w_m_tx_dv_nxt   = 1'b0;
        w_rx_byte_nxt   = r_rx_byte;
        w_rx_dv_nxt     = 1'b0;
        w_rx_last_nxt   = 1'b0;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_rem_nxt   = bus.i_Byte_Count;
                    w_cs_n_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_LEAD;
                end
            end
            S_LEAD: begin
                if (r_cnt == c_LEAD_LAST) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_FETCH: begin
                if (bus.i_TX_Valid) begin
                    w_m_tx_byte_nxt = bus.i_TX_Byte;
                    w_state_nxt     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.i_M_TX_Ready) begin
                    w_m_tx_dv_nxt = 1'b1;
                    w_state_nxt   = S_WAIT_RX;
                end
            end
            S_WAIT_RX: begin
                // rem is at least 1 here, so the decrement cannot wrap
                if (bus.i_M_RX_DV) begin
                    w_rx_byte_nxt = bus.i_M_RX_Byte;
                    w_rx_dv_nxt   = 1'b1;
                    w_rx_last_nxt = (r_rem == c_ONE);
                    w_rem_nxt     = r_rem - c_ONE;
                    w_state_nxt   = (r_rem == c_ONE) ? S_LAG : S_FETCH;
                end
            end
            S_LAG: begin
                // Master ready again means its trailing half-bit is finished.
                if (bus.i_M_TX_Ready) begin
                    w_cs_n_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.o_Busy      = (r_state != S_IDLE);
    assign bus.o_TX_Ready  = (r_state == S_FETCH);
    assign bus.o_RX_Byte   = r_rx_byte;
    assign bus.o_RX_DV     = r_rx_dv;
    assign bus.o_RX_Last   = r_rx_last;
    assign bus.o_Done      = r_done;
    assign bus.o_M_TX_Byte = r_m_tx_byte;
    assign bus.o_M_TX_DV   = r_m_tx_dv;
    assign bus.o_SPI_CS_n  = r_cs_n;
endmodule
`default_nettype wire

// File: tb/tb_spi_cs_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cs_txn_ctrl
// Brief    : Self-checking bench for spi_cs_txn_ctrl with a transaction-level
//            reference model, a randomized byte source and SPI master model.
// Revision : 1.0
// ============================================================================
module tb_spi_cs_txn_ctrl;
    localparam int MAX_BYTES = 8;
    localparam int LEAD      = 2;
    localparam int GAP       = 4;
    localparam int CW        = $clog2(MAX_BYTES + 1);

    logic clk   = 1'b0;
    logic rst_l = 1'b1;
    always #5 clk = ~clk;

    spi_cs_txn_ctrl_if #(.MAX_BYTES(MAX_BYTES)) bus ();

    spi_cs_txn_ctrl #(
        .MAX_BYTES        (MAX_BYTES),
        .CS_LEAD_CLKS     (LEAD),
        .CS_INACTIVE_CLKS (GAP)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_l),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // transaction-level expectations
    logic [7:0] src_q[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] rx_fixed[$];
    int n_exp, tx_seen, rx_seen, done_cnt, cs_falls, cs_rises, first_ready_seen;
    int cs_fall_cyc, cs_rise_cyc;
    logic cs_prev, ready_prev;
    // source and SPI master model state
    int stall, stall_max, fixed_idx, fixed_len, popped;
    int m_phase, m_cnt, m_post;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] b;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        // byte source: a handshake completed at the edge just passed
        if (bus.i_TX_Valid && ready_prev && src_q.size() > 0) begin
            b = src_q.pop_front();
            popped++;
            stall = (popped == fixed_idx) ? fixed_len : int'($urandom_range(0, stall_max));
        end
        // monitor
        if (bus.o_M_TX_DV) begin
            chk("mtx_dv_needs_ready", 32'(bus.i_M_TX_Ready), 32'd1);
            if (tx_seen < exp_tx.size()) chk("mtx_byte", 32'(bus.o_M_TX_Byte), 32'(exp_tx[tx_seen]));
            else chk("mtx_extra_issue", tx_seen, exp_tx.size() - 1);
            tx_seen++;
        end
        if (bus.o_RX_DV) begin
            if (rx_seen < exp_rx.size()) begin
                chk("rx_byte", 32'(bus.o_RX_Byte), 32'(exp_rx[rx_seen]));
                chk("rx_last", 32'(bus.o_RX_Last), 32'(rx_seen == n_exp - 1));
            end else chk("rx_extra_pulse", rx_seen, exp_rx.size() - 1);
            rx_seen++;
        end else if (bus.o_RX_Last) begin
            chk("rx_last_without_dv", 32'(bus.o_RX_Last), 32'd0);
        end
        if (cs_prev && !bus.o_SPI_CS_n) begin
            cs_falls++;
            cs_fall_cyc = cyc;
        end
        if (!cs_prev && bus.o_SPI_CS_n) begin
            cs_rises++;
            cs_rise_cyc = cyc;
            chk("cs_rise_after_last_rx", rx_seen, n_exp);
            chk("cs_rise_master_ready", 32'(bus.i_M_TX_Ready), 32'd1);
        end
        if (bus.o_TX_Ready && first_ready_seen == 0) begin
            first_ready_seen = 1;
            chk("cs_lead_cycles", cyc - cs_fall_cyc, LEAD);
        end
        if (bus.o_Done) begin
            done_cnt++;
            chk("done_gap_cycles", cyc - cs_rise_cyc, GAP);
            chk("done_cs_high", 32'(bus.o_SPI_CS_n), 32'd1);
        end
        cs_prev    = bus.o_SPI_CS_n;
        ready_prev = bus.o_TX_Ready;
        // SPI master model
        bus.i_M_RX_DV = 1'b0;
        if (bus.o_M_TX_DV) begin
            m_phase = 1;
            m_cnt   = $urandom_range(1, 5);
            bus.i_M_TX_Ready = 1'b0;
        end else if (m_phase == 1) begin
            m_cnt--;
            if (m_cnt == 0) begin
                b = (rx_fixed.size() > 0) ? rx_fixed.pop_front() : 8'($urandom);
                exp_rx.push_back(b);
                bus.i_M_RX_DV   = 1'b1;
                bus.i_M_RX_Byte = b;
                m_phase = 2;
                m_cnt   = (m_post >= 0) ? m_post : int'($urandom_range(0, 2));
            end
        end else if (m_phase == 2) begin
            if (m_cnt == 0) begin
                bus.i_M_TX_Ready = 1'b1;
                m_phase = 0;
            end else m_cnt--;
        end else begin
            bus.i_M_TX_Ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                bus.i_M_RX_DV   = 1'b1;          // stray pulse, must be ignored
                bus.i_M_RX_Byte = 8'($urandom);
            end
        end
        // byte source drive
        if (src_q.size() > 0) begin
            if (stall > 0) begin
                bus.i_TX_Valid = 1'b0;
                stall--;
            end else begin
                bus.i_TX_Valid = 1'b1;
                bus.i_TX_Byte  = src_q[0];
            end
        end else begin
            bus.i_TX_Valid = 1'b0;
            bus.i_TX_Byte  = 8'($urandom);
        end
    endtask

    task automatic load_txn(input int n, input int smax, input int fidx, input int flen, input int post);
        logic [7:0] b;
        src_q.delete(); exp_tx.delete(); exp_rx.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            src_q.push_back(b);
            exp_tx.push_back(b);
        end
        n_exp = n; tx_seen = 0; rx_seen = 0; done_cnt = 0;
        cs_falls = 0; cs_rises = 0; first_ready_seen = 0;
        stall_max = smax; fixed_idx = fidx; fixed_len = flen; popped = 0; stall = 0;
        m_post = post;
    endtask

    task automatic start_txn();
        bus.i_Byte_Count = CW'(n_exp);
        bus.i_Start = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        chk("busy_after_start", 32'(bus.o_Busy), 32'd1);
        chk("cs_low_after_start", 32'(bus.o_SPI_CS_n), 32'd0);
    endtask

    task automatic finish_txn(input bit start_mid, input bit start_done);
        int guard = 0;
        while (done_cnt == 0 && guard < 3000) begin
            if (start_mid && guard == 6) begin
                bus.i_Start      = 1'b1;
                bus.i_Byte_Count = CW'($urandom_range(1, MAX_BYTES));
            end
            tick();
            bus.i_Start = 1'b0;
            guard++;
        end
        chk("done_within_budget", done_cnt, 1);
        if (start_done) begin
            bus.i_Start      = 1'b1;
            bus.i_Byte_Count = CW'(n_exp);
        end
        tick();
        bus.i_Start = 1'b0;
        chk("idle_after_done_busy", 32'(bus.o_Busy), 32'd0);
        chk("idle_after_done_cs", 32'(bus.o_SPI_CS_n), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("txn_issue_count", tx_seen, n_exp);
        chk("txn_rx_count", rx_seen, n_exp);
        chk("txn_done_count", done_cnt, 1);
        chk("txn_cs_single_fall", cs_falls, 1);
        chk("txn_cs_single_rise", cs_rises, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs_n"},     32'(bus.o_SPI_CS_n),  32'd1);
        chk({tag, "_busy"},     32'(bus.o_Busy),      32'd0);
        chk({tag, "_tx_ready"}, 32'(bus.o_TX_Ready),  32'd0);
        chk({tag, "_m_tx_dv"},  32'(bus.o_M_TX_DV),   32'd0);
        chk({tag, "_m_tx_byte"},32'(bus.o_M_TX_Byte), 32'd0);
        chk({tag, "_rx_dv"},    32'(bus.o_RX_DV),     32'd0);
        chk({tag, "_rx_last"},  32'(bus.o_RX_Last),   32'd0);
        chk({tag, "_rx_byte"},  32'(bus.o_RX_Byte),   32'd0);
        chk({tag, "_done"},     32'(bus.o_Done),      32'd0);
    endtask

    task automatic reset_models();
        src_q.delete(); exp_tx.delete(); exp_rx.delete(); rx_fixed.delete();
        m_phase = 0; m_cnt = 0; m_post = -1;
        bus.i_M_TX_Ready = 1'b1;
        bus.i_M_RX_DV    = 1'b0;
        bus.i_TX_Valid   = 1'b0;
        bus.i_Start      = 1'b0;
        cs_prev = 1'b1; ready_prev = 1'b0;
        n_exp = 0; tx_seen = 0; rx_seen = 0; done_cnt = 0;
        stall = 0; stall_max = 0; fixed_idx = -1; fixed_len = 0; popped = 0;
    endtask

    initial begin
        int guard;
        bus.i_Byte_Count = '0;
        bus.i_TX_Byte    = '0;
        bus.i_M_RX_Byte  = '0;
        reset_models();
        #1 rst_l = 1'b0;
        #1 chk_reset_outputs("reset");
        tick(); tick();
        rst_l = 1'b1;
        tick();

        // 1: single byte, fixed data
        load_txn(1, 0, -1, 0, 1);
        src_q[0] = 8'hA5; exp_tx[0] = 8'hA5;
        rx_fixed.push_back(8'h3C);
        start_txn();
        finish_txn(1'b0, 1'b0);

        // 2: three bytes, source stalls 10 cycles before byte 2
        load_txn(3, 0, 1, 10, -1);
        for (int i = 0; i < 3; i++) begin
            src_q[i]  = 8'(i + 1);
            exp_tx[i] = 8'(i + 1);
        end
        start_txn();
        finish_txn(1'b0, 1'b0);

        // 3: illegal byte counts
        load_txn(0, 0, -1, 0, -1);
        bus.i_Byte_Count = '0;
        bus.i_Start = 1'b1;
        tick();
        chk("illegal0_busy", 32'(bus.o_Busy), 32'd0);
        chk("illegal0_cs", 32'(bus.o_SPI_CS_n), 32'd1);
        bus.i_Byte_Count = CW'(MAX_BYTES + 1);
        tick();
        bus.i_Start = 1'b0;
        chk("illegal9_busy", 32'(bus.o_Busy), 32'd0);
        chk("illegal9_cs", 32'(bus.o_SPI_CS_n), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("illegal_no_issue", tx_seen, 0);
        chk("illegal_no_cs_fall", cs_falls, 0);

        // 4: starts while busy and in the o_Done cycle are ignored
        load_txn(2, 1, -1, 0, -1);
        start_txn();
        finish_txn(1'b1, 1'b1);

        // 5: reset while waiting for the received byte
        load_txn(4, 1, -1, 0, -1);
        start_txn();
        guard = 0;
        while (m_phase != 1 && guard < 200) begin
            tick();
            guard++;
        end
        chk("reached_wait_rx", m_phase, 1);
        rst_l = 1'b0;
        #1 chk_reset_outputs("midreset");
        reset_models();
        tick(); tick();
        chk_reset_outputs("held_reset");
        rst_l = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_cs_high", 32'(bus.o_SPI_CS_n), 32'd1);
        load_txn(2, 1, -1, 0, -1);
        start_txn();
        finish_txn(1'b0, 1'b0);

        // 6: maximum length, master ready held off 3 cycles after each byte
        load_txn(MAX_BYTES, 1, -1, 0, 3);
        start_txn();
        finish_txn(1'b0, 1'b0);

        // randomized transactions
        for (int t = 0; t < 8; t++) begin
            load_txn(int'($urandom_range(1, MAX_BYTES)), int'($urandom_range(0, 4)), -1, 0,
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4)) : -1);
            start_txn();
            finish_txn($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
